sp_fifo_drain: RTL and testbench

Read-side controller placed directly downstream of the 16-deep sp_fifo. The FIFO has no flags, so this block snoops its write strobe and keeps an occupancy count. It issues fifo_rd_en only when data exists and there is room downstream. It captures the FIFO's registered dout and presents it on a valid/ready stream through a 2-entry output buffer, sustaining 1 word/cycle.

---
 rtl/sp_fifo_drain.sv | 167 ++++++++++++++++
 tb/tb_sp_fifo_drain.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_fifo_drain.sv
// ---------------------------------------------------------------------------
// sp_fifo_drain
//
// Read-side controller for a flag-less 16-deep sp_fifo. The FIFO write strobe
// is snooped to track how many words the FIFO holds. A read is issued only
// when a word is present and the 2-entry output buffer will have room for it
// when it arrives. The FIFO's registered read data is captured one cycle
// after the read strobe and is presented on a valid/ready stream.
//
// Handshake: a word transfers on every rising clk edge where m_valid and
// m_ready are both high. While m_valid is high and m_ready is low, m_data is
// held stable. m_valid never drops without a transfer.
//
// Ports
//   clk         clock shared with sp_fifo
//   rst         asynchronous active-high reset (sp_fifo shares this reset)
//   fifo_wr_en  copy of the upstream write strobe into sp_fifo
//   fifo_rd_en  read strobe to sp_fifo
//   fifo_dout   sp_fifo registered read data
//   m_valid     output word valid
//   m_ready     downstream accepts the word
//   m_data      output word (head of the output buffer)
//   occupancy   words currently held in sp_fifo
//   overflow    sticky: a write arrived while the FIFO was full with no read
// ---------------------------------------------------------------------------
module sp_fifo_drain #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_wr_en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic              overflow
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [OCC_W-1:0]  occ_q;
  logic              overflow_q;
  logic              inflight_q;    // a read was sampled last edge; dout valid now
  logic [1:0]        buf_cnt_q;     // 0..2 words in the output buffer
  logic [DATA_W-1:0] buf_head_q;    // entry 0: the word on m_data
  logic [DATA_W-1:0] buf_tail_q;    // entry 1: next word behind the head

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic       pop;
  logic       capture;
  logic [2:0] outstanding;          // words owed to the buffer after this edge

  assign pop     = m_valid & m_ready;
  assign capture = inflight_q;

  // buf_cnt + inflight never exceeds 2, and pop implies buf_cnt >= 1, so
  // this never goes negative. A 3-bit sum keeps the arithmetic plainly safe.
  assign outstanding = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  // Reads look only at words already counted; a write landing this same
  // cycle is not yet readable from the FIFO.
  assign fifo_rd_en = (occ_q != '0) && (outstanding < 3'd2);

  assign m_valid   = (buf_cnt_q != 2'd0);
  assign m_data    = buf_head_q;
  assign occupancy = occ_q;
  assign overflow  = overflow_q;

  // ---------------------------------------------------------------------
  // Occupancy tracking
  // ---------------------------------------------------------------------
  logic [OCC_W-1:0] occ_d;
  logic             overflow_d;

  always_comb begin
    occ_d      = occ_q;
    overflow_d = overflow_q;
    case ({fifo_wr_en, fifo_rd_en})
      2'b10: begin
        if (occ_q == OCC_FULL) begin
          // The FIFO has silently overwritten its oldest word; the count
          // stays saturated and the event is latched until reset.
          overflow_d = 1'b1;
        end else begin
          occ_d = occ_q + 1'b1;
        end
      end
      2'b01:   occ_d = occ_q - 1'b1;   // rd_en implies occ_q != 0
      default: occ_d = occ_q;          // idle, or write and read cancel out
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      overflow_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
      inflight_q <= fifo_rd_en;
    end
  end

  // ---------------------------------------------------------------------
  // Output buffer: 2-entry shift queue, head drives m_data.
  // ---------------------------------------------------------------------
  logic [1:0]        buf_cnt_d;
  logic [DATA_W-1:0] buf_head_d;
  logic [DATA_W-1:0] buf_tail_d;

  always_comb begin
    buf_cnt_d  = buf_cnt_q;
    buf_head_d = buf_head_q;
    buf_tail_d = buf_tail_q;
    case ({capture, pop})
      2'b10: begin
        // Append. With two words buffered no read was ever issued, so a
        // capture only meets buf_cnt of 0 or 1.
        if (buf_cnt_q == 2'd0) begin
          buf_head_d = fifo_dout;
        end else begin
          buf_tail_d = fifo_dout;
        end
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b01: begin
        buf_head_d = buf_tail_q;
        buf_cnt_d  = buf_cnt_q - 2'd1;
      end
      2'b11: begin
        // Pop and capture together: count unchanged, order preserved.
        if (buf_cnt_q == 2'd1) begin
          buf_head_d = fifo_dout;
        end else begin
          buf_head_d = buf_tail_q;
          buf_tail_d = fifo_dout;
        end
      end
      default: begin
        buf_cnt_d = buf_cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt_q  <= 2'd0;
      buf_head_q <= '0;
      buf_tail_q <= '0;
    end else begin
      buf_cnt_q  <= buf_cnt_d;
      buf_head_q <= buf_head_d;
      buf_tail_q <= buf_tail_d;
    end
  end

endmodule

// File: tb/tb_sp_fifo_drain.sv
// ---------------------------------------------------------------------------
// tb_sp_fifo_drain
//
// Bench for sp_fifo_drain. A behavioural 16-deep sp_fifo with registered
// read data sits in front of the DUT and shares its reset. Words are pushed
// to exp_q as they are written into the FIFO and popped/compared whenever
// the DUT transfers a word on its output stream.
// ---------------------------------------------------------------------------
module tb_sp_fifo_drain;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // DUT and FIFO model signals
  // ---------------------------------------------------------------------
  logic              fifo_wr_en = 1'b0;
  logic [DATA_W-1:0] fifo_din   = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [OCC_W-1:0]  occupancy;
  logic              overflow;

  sp_fifo_drain #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_wr_en (fifo_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occupancy  (occupancy),
    .overflow   (overflow)
  );

  // Flag-less single-port FIFO with registered read data.
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [3:0]        wr_ptr;
  logic [3:0]        rd_ptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_dout <= '0;
    end else begin
      if (fifo_wr_en) begin
        fifo_mem[wr_ptr] <= fifo_din;
        wr_ptr           <= wr_ptr + 4'd1;
      end
      if (fifo_rd_en) begin
        fifo_dout <= fifo_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Scoreboard and counters
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] exp_q[$];
  int tests_run = 0;
  int failures  = 0;

  int cyc       = 0;
  int valid_cnt = 0;
  int first_cyc = -1;
  int last_cyc  = -1;
  int rd_cnt    = 0;
  int occ_peak  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change #1 after the rising edge, so everything is settled here.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) rd_cnt = rd_cnt + 1;
      if (int'(occupancy) > occ_peak) occ_peak = int'(occupancy);
      if (m_valid && m_ready) begin
        logic [DATA_W-1:0] exp_word;
        tests_run = tests_run + 1;
        valid_cnt = valid_cnt + 1;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_word: got m_data=0x%02h, expected no transfer", m_data);
        end else begin
          exp_word = exp_q.pop_front();
          if (m_data !== exp_word) begin
            failures = failures + 1;
            $display("FAIL stream_order: got m_data=0x%02h, expected 0x%02h", m_data, exp_word);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic clear_stats();
    valid_cnt = 0;
    first_cyc = -1;
    last_cyc  = -1;
    rd_cnt    = 0;
    occ_peak  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    fifo_wr_en = 1'b0;
    m_ready    = 1'b0;
    exp_q.delete();
    #3;
    rst = 1'b0;
  endtask

  // Drives one write for one edge; returns #1 after that edge with wr low.
  task automatic write_one(input logic [DATA_W-1:0] d);
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b1;
    fifo_din   = d;
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
  endtask

  task automatic wait_drained(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    tests_run = tests_run + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests_run = tests_run + 1;
    if ({m_valid, fifo_rd_en, overflow} !== 3'b000 || occupancy !== '0 || m_data !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_outputs: got valid=%b rd=%b ovf=%b occ=%0d data=0x%02h, required all 0",
               m_valid, fifo_rd_en, overflow, occupancy, m_data);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b0 || occupancy !== '0 || fifo_rd_en !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_idle: got valid=%b occ=%0d rd=%b, required 0/0/0",
               m_valid, occupancy, fifo_rd_en);
    end
  endtask

  task automatic test_single_word();
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b1;
    fifo_din   = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk);              // E0: write sampled
    #1;
    fifo_wr_en = 1'b0;
    tests_run = tests_run + 1;
    if (occupancy !== 5'd1 || fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL single_e0: got occ=%0d rd=%b valid=%b, required 1/1/0",
               occupancy, fifo_rd_en, m_valid);
    end
    @(posedge clk);              // E1: read sampled
    #1;
    tests_run = tests_run + 1;
    if (occupancy !== 5'd0 || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL single_e1: got occ=%0d rd=%b valid=%b, required 0/0/0",
               occupancy, fifo_rd_en, m_valid);
    end
    @(posedge clk);              // E2: data captured
    #1;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b1 || m_data !== 8'hA5) begin
      failures = failures + 1;
      $display("FAIL single_e2: got valid=%b data=0x%02h, required 1/0xa5", m_valid, m_data);
    end
    @(posedge clk);
    #1;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL single_e3: got valid=%b, required 0", m_valid);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      fifo_wr_en = 1'b1;
      fifo_din   = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
    wait_drained("stream");
    tests_run = tests_run + 1;
    if (valid_cnt != 16 || (last_cyc - first_cyc + 1) != 16) begin
      failures = failures + 1;
      $display("FAIL stream_rate: got %0d words over %0d cycles, required 16 over 16",
               valid_cnt, last_cyc - first_cyc + 1);
    end
    tests_run = tests_run + 1;
    if (occ_peak > 2) begin
      failures = failures + 1;
      $display("FAIL stream_peak_occ: got %0d, required <= 2", occ_peak);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    clear_stats();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      fifo_wr_en = 1'b1;
      fifo_din   = 8'(i);
      exp_q.push_back(8'(i));
    end
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b1 || m_data !== 8'h00 || rd_cnt != 2 || occupancy !== 5'd6) begin
      failures = failures + 1;
      $display("FAIL backpressure_hold: got valid=%b data=0x%02h reads=%0d occ=%0d, required 1/0x00/2/6",
               m_valid, m_data, rd_cnt, occupancy);
    end
    for (int i = 0; i < 40; i++) begin
      m_ready = ~i[0];
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    wait_drained("backpressure");
    tests_run = tests_run + 1;
    if (valid_cnt != 8 || occupancy !== '0 || m_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL backpressure_total: got words=%0d occ=%0d valid=%b, required 8/0/0",
               valid_cnt, occupancy, m_valid);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      fifo_wr_en = 1'b1;
      fifo_din   = 8'h40 + 8'(i);
      exp_q.push_back(8'h40 + 8'(i));
    end
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run = tests_run + 1;
    if (occupancy !== 5'd14 || overflow !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL overflow_16w: got occ=%0d ovf=%b, required 14/0", occupancy, overflow);
    end
    write_one(8'h50);
    write_one(8'h51);
    tests_run = tests_run + 1;
    if (occupancy !== 5'd16 || overflow !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL overflow_full: got occ=%0d ovf=%b, required 16/0", occupancy, overflow);
    end
    write_one(8'h52);
    tests_run = tests_run + 1;
    if (occupancy !== 5'd16 || overflow !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overflow_set: got occ=%0d ovf=%b, required 16/1", occupancy, overflow);
    end
    // Write and read on the same edge while full.
    fifo_wr_en = 1'b1;
    fifo_din   = 8'h53;
    exp_q.push_back(8'h53);
    m_ready = 1'b1;
    #1;
    tests_run = tests_run + 1;
    if (fifo_rd_en !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overflow_rd_at_full: got rd=%b, required 1", fifo_rd_en);
    end
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
    m_ready    = 1'b0;
    tests_run = tests_run + 1;
    if (occupancy !== 5'd16 || overflow !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL overflow_wr_rd_full: got occ=%0d ovf=%b, required 16/1", occupancy, overflow);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b1;
    fifo_din   = 8'hC1;
    exp_q.push_back(8'hC1);
    @(posedge clk);
    #1;
    fifo_din = 8'hC2;
    exp_q.push_back(8'hC2);
    @(posedge clk);
    #1;
    fifo_din = 8'hC3;
    exp_q.push_back(8'hC3);
    @(posedge clk);
    #1;
    // occupancy 1, one word buffered, one read in flight
    tests_run = tests_run + 1;
    if (occupancy !== 5'd1 || m_valid !== 1'b1 || m_data !== 8'hC1 || fifo_rd_en !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL simul_setup: got occ=%0d valid=%b data=0x%02h rd=%b, required 1/1/0xc1/0",
               occupancy, m_valid, m_data, fifo_rd_en);
    end
    fifo_din = 8'hC4;
    exp_q.push_back(8'hC4);
    m_ready = 1'b1;
    #1;
    tests_run = tests_run + 1;
    if (fifo_rd_en !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL simul_rd: got rd=%b, required 1", fifo_rd_en);
    end
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b0;
    m_ready    = 1'b0;
    tests_run = tests_run + 1;
    if (occupancy !== 5'd1 || m_valid !== 1'b1 || m_data !== 8'hC2) begin
      failures = failures + 1;
      $display("FAIL simul_advance: got occ=%0d valid=%b data=0x%02h, required 1/1/0xc2",
               occupancy, m_valid, m_data);
    end
    m_ready = 1'b1;
    wait_drained("simul");
    m_ready = 1'b0;
  endtask

  // Entered from the full, overflowed state left by test_overflow.
  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b1;
    fifo_din   = 8'h77;
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    tests_run = tests_run + 1;
    if ({m_valid, fifo_rd_en, overflow} !== 3'b000 || occupancy !== '0) begin
      failures = failures + 1;
      $display("FAIL reset_mid_async: got valid=%b rd=%b ovf=%b occ=%0d, required all 0",
               m_valid, fifo_rd_en, overflow, occupancy);
    end
    fifo_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    clear_stats();
    @(posedge clk);
    #1;
    fifo_wr_en = 1'b1;
    fifo_din   = 8'h3C;
    exp_q.push_back(8'h3C);
    @(posedge clk);              // E0
    #1;
    fifo_wr_en = 1'b0;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_mid_e0: got valid=%b, required 0", m_valid);
    end
    @(posedge clk);              // E1
    #1;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL reset_mid_e1: got valid=%b, required 0", m_valid);
    end
    @(posedge clk);              // E2
    #1;
    tests_run = tests_run + 1;
    if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
      failures = failures + 1;
      $display("FAIL reset_mid_e2: got valid=%b data=0x%02h, required 1/0x3c", m_valid, m_data);
    end
    repeat (5) @(posedge clk);
    #1;
    tests_run = tests_run + 1;
    if (valid_cnt != 1 || exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL reset_mid_alone: got %0d words, %0d pending, required 1/0",
               valid_cnt, exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------
  initial begin
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
